mips_bus_wait_ram: RTL and testbench

MIPS_BUS_WAIT_RAM -- requirements
Module: mips_bus_wait_ram

---
 rtl/mips_bus_wait_ram.sv | 140 ++++++++++++++
 tb/tb_mips_bus_wait_ram.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_wait_ram.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_wait_ram
// Description : Avalon-MM slave RAM for the MIPS CPU bus with a programmable
//               number of wait states, byte-lane writes, a sticky bus-error
//               flag and a saturating completed-transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_wait_ram #(
  parameter int          WAIT_CYCLES = 2,
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        bus_error,
  output logic [15:0] access_count
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  // Byte span of the array; one bit wider than the bus so DEPTH_LOG2=30 fits.
  localparam logic [32:0] SPAN      = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] readdata_q;
  logic        bus_error_q;
  logic [15:0] count_q;
  logic [15:0] count_d;

  logic [31:0] mem_q [DEPTH];

  logic                  req;
  logic [31:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  enter_ack;
  logic                  do_write;

  assign req      = read | write;
  assign offset   = address - BASE_ADDR;
  // Alignment, lower bound and upper bound; the offset wraps below the base,
  // so the explicit lower-bound compare is required.
  assign in_range = (address[1:0] == 2'b00) && (address >= BASE_ADDR) &&
                    ({1'b0, offset} < SPAN);
  assign word_idx = offset[DEPTH_LOG2+1:2];

  // The edge that moves the FSM into ACK; read data is captured here.
  assign enter_ack = req && (((state_q == S_IDLE) && (WAIT_CYCLES == 0)) ||
                             ((state_q == S_WAIT) && (cnt_q == 4'd0)));

  // Writes commit on the edge leaving ACK; a simultaneous read wins.
  assign do_write = (state_q == S_ACK) && write && !read && in_range;

  assign count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  // Stall the master until the ACK cycle; never stall while held in reset.
  assign waitrequest  = reset & req & (state_q != S_ACK);
  assign readdata     = readdata_q;
  assign bus_error    = bus_error_q;
  assign access_count = count_q;

  // Access FSM together with its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      readdata_q  <= 32'h0;
      bus_error_q <= 1'b0;
      count_q     <= 16'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (WAIT_CYCLES == 0) begin
              state_q <= S_ACK;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            // Master withdrew the request: abandon the access silently.
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd0) begin
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          count_q <= count_d;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (enter_ack) begin
        if (read) begin
          readdata_q <= in_range ? mem_q[word_idx] : 32'h0;
        end
        if (!in_range || (read && write)) begin
          bus_error_q <= 1'b1;
        end
      end
    end
  end

  // Storage array with per-byte write enables; intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) begin
          mem_q[word_idx][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_wait_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_wait_ram
// Description : Self-checking bench for mips_bus_wait_ram with a word-level
//               reference model (associative memory, sticky error, counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_wait_ram;

  localparam int          WC   = 2;
  localparam int          DL2  = 10;
  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;
  logic [15:0] access_count;

  logic [31:0] address0;
  logic        read0;
  logic        w0_wait;
  logic [31:0] w0_rdata;
  logic        w0_err;
  logic [15:0] w0_cnt;

  always #5 clk = ~clk;

  mips_bus_wait_ram #(.WAIT_CYCLES(WC), .DEPTH_LOG2(DL2), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .bus_error(bus_error), .access_count(access_count)
  );

  mips_bus_wait_ram #(.WAIT_CYCLES(0), .DEPTH_LOG2(4), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .reset(reset), .address(address0), .read(read0), .write(1'b0),
    .byteenable(4'h0), .writedata(32'h0), .waitrequest(w0_wait),
    .readdata(w0_rdata), .bus_error(w0_err), .access_count(w0_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] mm [int];
  logic [31:0] exp_rd  = 32'h0;
  logic        exp_err = 1'b0;
  int          exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One complete access; entered and left just after a rising edge.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    longint la;
    logic   inr;
    int     idx;
    int     hi;
    la  = longint'({32'b0, a});
    inr = (a[1:0] == 2'b00) && (la >= longint'({32'b0, BASE})) &&
          (la < longint'({32'b0, BASE}) + 4 * (longint'(1) << DL2));
    idx = inr ? int'((la - longint'({32'b0, BASE})) / 4) : 0;
    if (rd) exp_rd = (inr && mm.exists(idx)) ? mm[idx] : 32'h0;
    address = a; read = rd; write = wr; byteenable = be; writedata = d;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!waitrequest) break;
      hi++;
      @(posedge clk); #1;
    end
    chk("wait_high_cycles", hi, WC + 1);
    chk("readdata_ack", readdata, exp_rd);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    if (wr && !rd && inr) begin
      logic [31:0] w;
      w = mm.exists(idx) ? mm[idx] : 32'h0;
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      mm[idx] = w;
    end
    if (!inr || (rd && wr)) exp_err = 1'b1;
    if (exp_cnt < 65535) exp_cnt++;
    @(negedge clk);
    chk("access_count", {16'h0, access_count}, exp_cnt);
    chk("bus_error", {31'h0, bus_error}, {31'h0, exp_err});
    chk("wait_idle", {31'h0, waitrequest}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; address = BASE; read = 1'b1; write = 1'b0;
    byteenable = 4'h0; writedata = 32'h0; address0 = BASE; read0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait_forced", {31'h0, waitrequest}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
    chk("rst_count", {16'h0, access_count}, 32'h0);
    read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Write then read back one word.
    xfer(1'b0, 1'b1, 32'hBFC00010, 4'hF, 32'hDEADBEEF);
    xfer(1'b1, 1'b0, 32'hBFC00010, 4'h0, 32'h0);
    chk("rb_deadbeef", readdata, 32'hDEADBEEF);
    chk("count_two", {16'h0, access_count}, 32'd2);

    // Initialise a window of words so every later read is defined.
    for (int i = 0; i < 16; i++) xfer(1'b0, 1'b1, BASE + 32'(4 * i), 4'hF, $urandom);

    // Byte-lane merge.
    xfer(1'b0, 1'b1, BASE + 32'h14, 4'hF, 32'h11223344);
    xfer(1'b0, 1'b1, BASE + 32'h14, 4'b0101, 32'hAABBCCDD);
    xfer(1'b1, 1'b0, BASE + 32'h14, 4'h0, 32'h0);
    chk("byte_merge", readdata, 32'h11BB33DD);

    // Random in-range traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int op;
      op = int'($urandom_range(0, 2));
      if (op == 0) xfer(1'b1, 1'b0, BASE + 32'(4 * $urandom_range(0, 15)), 4'h0, 32'h0);
      else         xfer(1'b0, 1'b1, BASE + 32'(4 * $urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), $urandom);
    end
    chk("no_error_yet", {31'h0, bus_error}, 32'h0);

    // Request withdrawn during the second WAIT cycle.
    xfer(1'b1, 1'b0, BASE + 32'h8, 4'h0, 32'h0);
    address = BASE + 32'hC; read = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    read = 1'b0;
    @(negedge clk);
    chk("abort_wait_low", {31'h0, waitrequest}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_readdata", readdata, exp_rd);
    chk("abort_count", {16'h0, access_count}, exp_cnt);
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, BASE + 32'hC, 4'h0, 32'h0);

    // Address errors, write suppression and read+write collision.
    xfer(1'b1, 1'b0, 32'h00000000, 4'h0, 32'h0);
    chk("oor_read_zero", readdata, 32'h0);
    xfer(1'b1, 1'b0, 32'hBFC00002, 4'h0, 32'h0);
    chk("misaligned_zero", readdata, 32'h0);
    xfer(1'b0, 1'b1, BASE + 32'h1A, 4'hF, 32'h5A5A5A5A);
    xfer(1'b0, 1'b1, BASE + 32'h1000, 4'hF, 32'h5A5A5A5A);
    xfer(1'b1, 1'b1, BASE + 32'h1C, 4'hF, 32'hA5A5A5A5);
    xfer(1'b1, 1'b0, BASE + 32'h18, 4'h0, 32'h0);
    xfer(1'b1, 1'b0, BASE + 32'h1C, 4'h0, 32'h0);
    xfer(1'b1, 1'b0, BASE + 32'h0, 4'h0, 32'h0);
    chk("error_sticky", {31'h0, bus_error}, 32'h1);

    // Reset in the middle of a write.
    address = BASE + 32'h24; write = 1'b1; byteenable = 4'hF; writedata = 32'hCAFEF00D;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_wait", {31'h0, waitrequest}, 32'h0);
    chk("midrst_readdata", readdata, 32'h0);
    chk("midrst_error", {31'h0, bus_error}, 32'h0);
    chk("midrst_count", {16'h0, access_count}, 32'h0);
    exp_rd = 32'h0; exp_err = 1'b0; exp_cnt = 0;
    write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, BASE + 32'h24, 4'h0, 32'h0);

    // Zero-wait instance under a continuous read.
    read0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("w0_pattern", {31'h0, w0_wait}, (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    @(posedge clk); #1;
    read0 = 1'b0;
    @(negedge clk);
    chk("w0_count", {16'h0, w0_cnt}, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
